// File: rtl/jt12_lfo_pkg.sv
// Shared constants for the JT12 low-frequency oscillator: period table,
// state encodings and the register address it answers to.
package jt12_lfo_pkg;

  typedef enum logic {
    LFO_IDLE = 1'b0,
    LFO_RUN  = 1'b1
  } lfo_state_t;

  localparam logic [7:0] LFO_REG_ADDR = 8'h22;

  // Samples per LFO step, indexed by the 3-bit frequency select
  localparam logic [0:7][6:0] LFO_PERIOD = '{
    7'd108, 7'd77, 7'd71, 7'd67, 7'd62, 7'd44, 7'd8, 7'd5
  };

  function automatic logic [6:0] lfo_period_m1(input logic [2:0] freq);
    return LFO_PERIOD[freq] - 7'd1;
  endfunction

endpackage

// File: rtl/jt12_lfo_div.sv
// Per-sample divider: counts zero strobes and emits a one-cycle step pulse
// once the count reaches the period selected by freq.
module jt12_lfo_div
  import jt12_lfo_pkg::*;
#(
  parameter int DIV_W = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [2:0] freq,
  input  logic       zero,
  output logic       step
);

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] limit;
  logic             at_limit;

  assign limit    = DIV_W'(lfo_period_m1(freq));
  // >= rather than == so a switch to a shorter period wraps immediately
  assign at_limit = (div >= limit);
  assign step     = en & zero & at_limit;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
    end else if (!en) begin
      div <= '0;
    end else if (zero) begin
      div <= at_limit ? '0 : div + DIV_W'(1);
    end
  end

endmodule

// File: rtl/jt12_lfo.sv
// JT12 LFO top: register 0x22 latch, 7-bit LFO phase counter and the
// registered AM triangle / PM step decode.
module jt12_lfo
  import jt12_lfo_pkg::*;
#(
  parameter int DIV_W = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       zero,
  input  logic       lfo_wr,
  input  logic [3:0] lfo_din,
  output logic       lfo_en,
  output logic [6:0] am,
  output logic [4:0] pm,
  output logic [6:0] lfo_cnt
);

  lfo_state_t state;
  lfo_state_t state_nx;
  logic [2:0] freq;
  logic       run;
  logic       step;

  // State register; freq rides along with the enable bit from the same write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LFO_IDLE;
      freq  <= 3'd0;
    end else begin
      state <= state_nx;
      if (lfo_wr) freq <= lfo_din[2:0];
    end
  end

  // NOTE: combinational blocks assign a default first so no path leaves the
  // output unassigned and a latch cannot be inferred.
  always_comb begin
    state_nx = state;
    if (lfo_wr) state_nx = lfo_din[3] ? LFO_RUN : LFO_IDLE;
  end

  always_comb begin
    run = (state == LFO_RUN);
  end

  assign lfo_en = run;

  jt12_lfo_div #(.DIV_W(DIV_W)) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (run),
    .freq  (freq),
    .zero  (zero),
    .step  (step)
  );

  // NOTE: every register here is a small flop with async reset; there is no
  // memory array, so clearing everything on rst_n is cheap and safe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfo_cnt <= 7'd0;
    end else if (!run) begin
      lfo_cnt <= 7'd0;
    end else if (step) begin
      lfo_cnt <= lfo_cnt + 7'd1;
    end
  end

  // Outputs lag lfo_cnt by one clk and stay fixed until the next step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      am <= 7'd0;
      pm <= 5'd0;
    end else begin
      am <= lfo_cnt[6] ? {~lfo_cnt[5:0], 1'b0} : {lfo_cnt[5:0], 1'b0};
      pm <= lfo_cnt[6:2];
    end
  end

endmodule

// File: tb/tb_jt12_lfo.sv
// Directed self-checking bench for jt12_lfo: reset, rates, triangle shape,
// disable, mid-count frequency change and write/zero coincidence.
module tb_jt12_lfo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       zero;
  logic       lfo_wr;
  logic [3:0] lfo_din;
  logic       lfo_en;
  logic [6:0] am;
  logic [4:0] pm;
  logic [6:0] lfo_cnt;

  int checks = 0;
  int errors = 0;

  jt12_lfo #(.DIV_W(7)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .zero    (zero),
    .lfo_wr  (lfo_wr),
    .lfo_din (lfo_din),
    .lfo_en  (lfo_en),
    .am      (am),
    .pm      (pm),
    .lfo_cnt (lfo_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected triangle value for a given phase
  function automatic int tri_am(input int c);
    return (c < 64) ? 2 * c : 2 * (127 - c);
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One clk with zero high; returns at the negedge after the zero posedge
  task automatic zero_edge();
    zero = 1'b1;
    @(negedge clk);
    zero = 1'b0;
  endtask

  task automatic zeros(input int n);
    repeat (n) begin
      zero_edge();
      idle(23);
    end
  endtask

  task automatic write_reg(input logic [3:0] d);
    lfo_wr  = 1'b1;
    lfo_din = d;
    @(negedge clk);
    lfo_wr  = 1'b0;
  endtask

  initial begin
    int prev_am;
    int exp_cnt;
    int d;

    rst_n   = 1'b0;
    zero    = 1'b0;
    lfo_wr  = 1'b0;
    lfo_din = 4'h0;
    idle(3);
    check("rst_am", 32'(am), 32'd0);
    check("rst_pm", 32'(pm), 32'd0);
    check("rst_cnt", 32'(lfo_cnt), 32'd0);
    check("rst_en", 32'(lfo_en), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Fastest rate: freq 7, period 5
    write_reg(4'hF);
    check("fast_en", 32'(lfo_en), 32'd1);
    zeros(4);
    check("fast_cnt4", 32'(lfo_cnt), 32'd0);
    zero_edge();
    check("fast_cnt5", 32'(lfo_cnt), 32'd1);
    check("fast_am_lag", 32'(am), 32'd0);
    idle(1);
    check("fast_am5", 32'(am), 32'd2);
    check("fast_pm5", 32'(pm), 32'd0);
    idle(22);
    zeros(315);
    check("fast_cnt320", 32'(lfo_cnt), 32'd64);
    check("fast_am320", 32'(am), 32'd126);
    check("fast_pm320", 32'(pm), 32'd16);

    // Run on to 90, then disable
    zeros(130);
    check("dis_cnt90", 32'(lfo_cnt), 32'd90);
    check("dis_am90", 32'(am), 32'd74);
    check("dis_pm90", 32'(pm), 32'd22);
    write_reg(4'h0);
    check("dis_en", 32'(lfo_en), 32'd0);
    check("dis_cnt_hold", 32'(lfo_cnt), 32'd90);
    idle(1);
    check("dis_cnt_clr", 32'(lfo_cnt), 32'd0);
    check("dis_am_lag", 32'(am), 32'd74);
    idle(1);
    check("dis_am_clr", 32'(am), 32'd0);
    check("dis_pm_clr", 32'(pm), 32'd0);
    zeros(10);
    check("dis_cnt_idle", 32'(lfo_cnt), 32'd0);
    check("dis_am_idle", 32'(am), 32'd0);

    // Reset mid-count at lfo_cnt=37
    write_reg(4'hF);
    zeros(185);
    check("mrst_cnt37", 32'(lfo_cnt), 32'd37);
    rst_n = 1'b0;
    #1;
    check("mrst_cnt", 32'(lfo_cnt), 32'd0);
    check("mrst_am", 32'(am), 32'd0);
    check("mrst_pm", 32'(pm), 32'd0);
    check("mrst_en", 32'(lfo_en), 32'd0);
    idle(2);
    rst_n = 1'b1;
    zeros(10);
    check("mrst_post_cnt", 32'(lfo_cnt), 32'd0);
    check("mrst_post_en", 32'(lfo_en), 32'd0);
    check("mrst_post_am", 32'(am), 32'd0);

    // Triangle over a full 1024-zero cycle at freq 6 (period 8)
    write_reg(4'hE);
    prev_am = 0;
    for (int i = 1; i <= 1024; i++) begin
      zero_edge();
      idle(1);
      exp_cnt = (i / 8) % 128;
      check("tri_cnt", 32'(lfo_cnt), 32'(exp_cnt));
      if (i % 8 == 0) begin
        check("tri_am", 32'(am), 32'(tri_am(exp_cnt)));
        check("tri_even", 32'(am[0]), 32'd0);
        d = int'(am) - prev_am;
        if (exp_cnt == 64 || exp_cnt == 0)
          check("tri_flat", 32'(d), 32'd0);
        else
          check("tri_slope", 32'((d < 0) ? -d : d), 32'd2);
        prev_am = int'(am);
      end
      idle(22);
    end
    check("tri_end_cnt", 32'(lfo_cnt), 32'd0);

    // Mid-count change: freq 0 at div=50, then switch to freq 6
    write_reg(4'h8);
    zeros(50);
    check("mid_cnt_pre", 32'(lfo_cnt), 32'd0);
    write_reg(4'hE);
    zero_edge();
    check("mid_wrap", 32'(lfo_cnt), 32'd1);
    idle(23);
    zeros(7);
    check("mid_hold7", 32'(lfo_cnt), 32'd1);
    zero_edge();
    check("mid_step8", 32'(lfo_cnt), 32'd2);
    idle(23);

    // Write coincident with zero: freq 7 at div=4, write 0x8 on same edge
    write_reg(4'hF);
    zeros(4);
    check("coin_pre", 32'(lfo_cnt), 32'd2);
    zero    = 1'b1;
    lfo_wr  = 1'b1;
    lfo_din = 4'h8;
    @(negedge clk);
    zero    = 1'b0;
    lfo_wr  = 1'b0;
    check("coin_step", 32'(lfo_cnt), 32'd3);
    idle(23);
    zeros(107);
    check("coin_hold107", 32'(lfo_cnt), 32'd3);
    zero_edge();
    check("coin_step108", 32'(lfo_cnt), 32'd4);
    idle(2);
    check("coin_am", 32'(am), 32'd8);
    check("coin_pm", 32'(pm), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jt12_lfo.md
Name: jt12_lfo

Overview:
- Low-frequency oscillator for the JT12 FM core.
- Produces the 7-bit amplitude-modulation word `am` consumed by jt12_eg in its cycle VII.
- Produces a 5-bit phase-modulation step for the phase generator.
- Advances once per output sample, qualified by the `zero` strobe. Holds both outputs stable for the whole 24-slot sample so every operator sees the same value.

Parameters:
- DIV_W, 7, width of the per-sample divider counter; must hold 107.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- zero  in  1  one-cycle strobe marking the sample boundary (once every 24 clk in normal operation)
- lfo_wr  in  1  write strobe for the LFO register (YM2612 register 0x22)
- lfo_din  in  4  write data: bit3 = enable, bits2:0 = frequency select
- lfo_en  out  1  latched enable bit
- am  out  7  AM word, triangle 0..126, even values only
- pm  out  5  PM step index 0..31
- lfo_cnt  out  7  raw LFO phase, for debug and test

Behaviour:
- **Reset.** While rst_n is low, all registers clear asynchronously: enable, freq, divider, lfo_cnt, am and pm are all 0.
- **Register write.** When lfo_wr=1 at a clk edge, latch en = lfo_din[3] and freq = lfo_din[2:0]. The new values take effect from the next edge.
- **Period table.** The period is the number of samples per LFO step, indexed by freq 0..7: 108, 77, 71, 67, 62, 44, 8, 5.
- **States.** There are two:
  - IDLE (en=0):
    - divider and lfo_cnt are held at 0 synchronously on every clk, independent of `zero`.
    - am=0 and pm=0.
  - RUN (en=1), on each edge with zero=1:
    - If div >= period-1: div <= 0 and lfo_cnt <= lfo_cnt+1, wrapping 127 -> 0.
    - Otherwise div <= div+1.
    - The >= compare makes a mid-count frequency change to a shorter period wrap on the next zero rather than run to 127.
- **Transitions.**
  - IDLE -> RUN on a write with bit3=1. Counting starts from div=0 and lfo_cnt=0.
  - RUN -> IDLE on a write with bit3=0. The count clears at the next edge.
  - A write to RUN while already in RUN keeps lfo_cnt and div. Only the period changes.
- **Output decode.** am and pm are registered one clk after lfo_cnt changes, so both are stable before the next zero.
  - am = lfo_cnt[6] ? {~lfo_cnt[5:0], 1'b0} : {lfo_cnt[5:0], 1'b0}.
    - lfo_cnt 0..63 gives am rising 0..126.
    - lfo_cnt 64..127 gives am falling 126..0.
  - pm = lfo_cnt[6:2].
- **Latency.** From a zero edge that fires a step: lfo_cnt updates at that edge, and am/pm update at the following edge (1 clk).
- **Simultaneous events.**
  - lfo_wr and zero on the same edge: the divider step uses the old en and freq. The write takes effect afterwards.
  - Reset mid-count: immediate clear. After release, en=0 until the next write.
- **Arithmetic.** Divider compare is unsigned, DIV_W bits. lfo_cnt is modulo 128. No saturation is needed anywhere.

Decomposition:
- Shared include file (jt12_lfo_defs):
  - the 8-entry period constants;
  - the IDLE/RUN state encodings;
  - the register address constant 0x22.
- One natural sub-module, jt12_lfo_div:
  - inputs: freq, en, zero;
  - function: implements the divider and period lookup;
  - output: a one-cycle step pulse.
- The top module holds the register latch, lfo_cnt and the output decode.

Test Plan:
- **Reset behaviour:** assert rst_n=0 mid-run with lfo_cnt=37, then release. Required: am=0, pm=0, lfo_cnt=0, lfo_en=0 immediately and after release; no counting without a write.
- **Fastest rate:** write 0xF (en, freq 7), apply zero every 24 clk. Required:
  - lfo_cnt=1 after the 5th zero;
  - am=2 one clk later;
  - lfo_cnt=64 after 320 zeros, with am=126 and pm=16.
- **Triangle shape:** run freq 6 across a full cycle of 1024 zeros. Required:
  - am peaks at 126 at lfo_cnt 63/64;
  - am returns to 0 at lfo_cnt 127 and at the wrap to 0;
  - am values are always even;
  - adjacent am steps are ±2 except the plateau at the peak and the zero repeat at the wrap.
- **Disable:** write 0x0 while lfo_cnt=90. Required: lfo_cnt=0 at the next edge and am=0 one edge later; further zeros cause no change.
- **Mid-count frequency change:** with freq 0 and div=50, write 0xE (freq 6). Required: wrap on the next zero, lfo_cnt+1, div=0; then steps every 8 zeros.
- **Write coincident with zero:** freq 7 with div=4, and lfo_wr (0x8, freq 0) on the same edge as zero. Required: a step occurs using period 5, then the next step takes 108 zeros.
